mem_access_unit: RTL

Data-memory access unit directly downstream of the memory stage. Takes the stage's decoded load/store request (11-bit one-hot load/store info, ALU-computed address, rs2 store data) and runs a multi-cycle transaction on a 64-bit data bus. It returns the extended load data, or a store completion, to the memory stage, and holds the pipeline stalled while the transaction is in flight. It also generates byte strobes, detects misalignment, and times out hung bus transactions.

---
 rtl/mem_access_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Data-memory access unit: turns a one-hot load/store request into a 64-bit bus
// transaction, returning extended load data or a store completion.
module mem_access_unit #(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [10:0]       ls_info_i,
  input  logic [63:0]       addr_i,
  input  logic [63:0]       wdata_i,
  output logic              rsp_valid_o,
  output logic [63:0]       rsp_rdata_o,
  output logic              rsp_misalign_o,
  output logic              rsp_err_o,
  output logic              stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [63:0]       bus_wdata_o,
  output logic [7:0]        bus_wstrb_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [63:0]       bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [10:0]       info_q, info_d;
  logic [2:0]        off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [7:0]        wstrb_q, wstrb_d;
  logic              we_q, we_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;

  logic        isB, isH, isW, isD, multiHot, misAcc;
  logic [2:0]  off;
  logic [63:0] shifted, ext, replData;
  logic [7:0]  strb;

  // Decode the incoming request: access size, misalignment, strobes and lane replication.
  always_comb begin
    off      = addr_i[2:0];
    isB      = ls_info_i[0] | ls_info_i[4] | ls_info_i[7];
    isH      = ls_info_i[1] | ls_info_i[5] | ls_info_i[8];
    isW      = ls_info_i[2] | ls_info_i[6] | ls_info_i[9];
    isD      = ls_info_i[3] | ls_info_i[10];
    multiHot = (ls_info_i & (ls_info_i - 11'd1)) != 11'd0;
    misAcc   = (isH & off[0]) | (isW & (|off[1:0])) | (isD & (|off));
    strb     = 8'h00;
    replData = wdata_i;
    if (ls_info_i[7]) begin
      strb     = 8'h01 << off;
      replData = {8{wdata_i[7:0]}};
    end else if (ls_info_i[8]) begin
      strb     = 8'h03 << off;
      replData = {4{wdata_i[15:0]}};
    end else if (ls_info_i[9]) begin
      strb     = 8'h0F << off;
      replData = {2{wdata_i[31:0]}};
    end else if (ls_info_i[10]) begin
      strb     = 8'hFF;
    end
  end

  always_comb begin
    shifted = bus_rdata_i >> {off_q, 3'b000};
    ext     = shifted;
    if (info_q[0])      ext = {{56{shifted[7]}},  shifted[7:0]};
    else if (info_q[1]) ext = {{48{shifted[15]}}, shifted[15:0]};
    else if (info_q[2]) ext = {{32{shifted[31]}}, shifted[31:0]};
    else if (info_q[4]) ext = {56'd0, shifted[7:0]};
    else if (info_q[5]) ext = {48'd0, shifted[15:0]};
    else if (info_q[6]) ext = {32'd0, shifted[31:0]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    info_d  = info_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          info_d  = ls_info_i;
          off_d   = off;
          addr_d  = {addr_i[ADDR_W-1:3], 3'b000};
          wdata_d = replData;
          wstrb_d = strb;
          we_d    = |ls_info_i[10:7];
          rdata_d = 64'd0;
          mis_d   = 1'b0;
          err_d   = 1'b0;
          cnt_d   = 16'd0;
          if (multiHot) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (ls_info_i == 11'd0) begin
            state_d = RESP;
          end else if (misAcc) begin
            mis_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      // A grant or read response landing on the final counted cycle still completes normally.
      REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (bus_gnt_i) begin
          state_d = we_q ? RESP : WAIT;
        end else if (cnt_d == TMO) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (bus_rvalid_i) begin
          rdata_d = ext;
          state_d = RESP;
        end else if (cnt_d == TMO) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      info_q  <= 11'd0;
      off_q   <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 64'd0;
      wstrb_q <= 8'd0;
      we_q    <= 1'b0;
      rdata_q <= 64'd0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      info_q  <= info_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  // Bus and response fields are gated by state so they read as zero outside their phase.
  always_comb begin
    req_ready_o    = (state_q == IDLE);
    stall_o        = (state_q == REQ) | (state_q == WAIT);
    bus_req_o      = (state_q == REQ);
    bus_we_o       = bus_req_o & we_q;
    bus_addr_o     = bus_req_o ? addr_q : '0;
    bus_wdata_o    = bus_req_o ? wdata_q : 64'd0;
    bus_wstrb_o    = bus_req_o ? wstrb_q : 8'd0;
    rsp_valid_o    = (state_q == RESP);
    rsp_rdata_o    = rsp_valid_o ? rdata_q : 64'd0;
    rsp_misalign_o = rsp_valid_o & mis_q;
    rsp_err_o      = rsp_valid_o & err_q;
  end

endmodule
